sc_sng_pair: RTL and testbench

- Stochastic number generator pair, directly upstream of the stochastic multiplier.
- Converts two N-bit unsigned magnitudes (mantissa fields) into two unipolar bitstreams of length L = 2^N - 1.
- Each stream's ones-density equals value/L.
- Output streams can be decorrelated (independent LFSRs, used for AND-multiply) or fully correlated (shared LFSR, used for min/abs-subtract), selected per operation.

---
 rtl/sc_pkg.sv | 37 +++
 rtl/sc_lfsr.sv | 36 +++
 rtl/sc_sng_pair.sv | 127 ++++++++++++
 tb/tb_sc_sng_pair.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: LFSR tap table, stream length and
// the sequencing states used by the generator, multiplier and stream counter.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left-shifting Fibonacci feedback mask: bit (t-1) set for each tap x^t.
  function automatic logic [15:0] lfsr_taps(input int n);
    logic [15:0] m;
    case (n)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h00B8;
    endcase
    return m;
  endfunction

  function automatic int unsigned stream_len(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR; reset and load both restore SEED, so the
// all-zero state is unreachable as long as SEED is nonzero.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int          N    = 8,
  parameter int unsigned SEED = 32'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [N-1:0] Q
);

  localparam logic [15:0]  TAPS16 = lfsr_taps(N);
  localparam logic [N-1:0] TAPS   = TAPS16[N-1:0];
  localparam logic [N-1:0] SEED_V = SEED[N-1:0];

  logic [N-1:0] r_q;
  logic         w_fb;

  assign w_fb = ^(r_q & TAPS);
  assign Q    = r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= SEED_V;
    end else if (load) begin
      r_q <= SEED_V;
    end else if (en) begin
      r_q <= {r_q[N-2:0], w_fb};
    end
  end

endmodule

// File: rtl/sc_sng_pair.sv
// Stochastic number generator pair: turns two N-bit magnitudes into two
// unipolar bitstreams of length 2^N-1, decorrelated or sharing LFSR A.
module sc_sng_pair
  import sc_pkg::*;
#(
  parameter int          N      = 8,
  parameter int unsigned SEED_A = 32'hB4,
  parameter int unsigned SEED_B = 32'h5A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         corr,
  output logic         SA,
  output logic         SB,
  output logic         valid,
  output logic         last,
  output logic         busy,
  output logic         done,
  output state_t       dbg_state
);

  localparam logic [N-1:0] CNT_LAST = N'(stream_len(N) - 1);

  state_t       r_state, w_next;
  logic         w_load, w_step;
  logic [N-1:0] w_lfsr_a, w_lfsr_b, w_sel;
  logic [N-1:0] r_a, r_b, r_count;
  logic         r_corr;
  logic         r_sa, r_sb, r_valid, r_last, r_busy, r_done;

  sc_lfsr #(.N(N), .SEED(SEED_A)) u_lfsr_a (
    .clk (clk),
    .rst (rst),
    .load(w_load),
    .en  (w_step),
    .Q   (w_lfsr_a)
  );

  sc_lfsr #(.N(N), .SEED(SEED_B)) u_lfsr_b (
    .clk (clk),
    .rst (rst),
    .load(w_load),
    .en  (w_step),
    .Q   (w_lfsr_b)
  );

  assign w_sel = r_corr ? w_lfsr_a : w_lfsr_b;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_count == CNT_LAST) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Outputs lag the state by one edge, so busy covers every valid bit and done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_corr  <= 1'b0;
      r_count <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_corr  <= corr;
            r_count <= '0;
          end
        end
        RUN: begin
          r_sa    <= (w_lfsr_a <= r_a);
          r_sb    <= (w_sel <= r_b);
          r_valid <= 1'b1;
          r_last  <= (r_count == CNT_LAST);
          r_count <= r_count + 1'b1;
        end
        DONE:    r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign SA        = r_sa;
  assign SB        = r_sb;
  assign valid     = r_valid;
  assign last      = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sc_sng_pair.sv
// Directed bench for sc_sng_pair: stream lengths, ones densities, framing,
// correlation modes, ignored restarts, async abort and back-to-back reload.
module tb_sc_sng_pair;
  import sc_pkg::*;

  localparam int L = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       corr;
  logic       sa, sb, valid, last, busy, done;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  int         exp_and;

  int n_valid, n_sa, n_sb, n_and, n_eq, last_pos, done_at, busy_bad, seq_err;
  int lfsr_distinct, lfsr_dup;
  bit cap_sa[L];
  bit cap_sb[L];
  bit ref_sa[L];
  bit ref_sb[L];

  always #5 clk = ~clk;

  sc_sng_pair #(.N(8), .SEED_A(32'hB4), .SEED_B(32'h5A)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (a_in),
    .B        (b_in),
    .corr     (corr),
    .SA       (sa),
    .SB       (sb),
    .valid    (valid),
    .last     (last),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference stream for x^8+x^6+x^5+x^4+1, shifting left, from seeds B4/5A.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [7:0] xa, xb;
    logic       ea, eb;
    exp_q.delete();
    exp_and = 0;
    xa = 8'hB4;
    xb = 8'h5A;
    for (int t = 0; t < L; t++) begin
      ea = (xa <= a);
      eb = ((c ? xa : xb) <= b);
      exp_q.push_back({ea, eb});
      exp_and += int'(ea & eb);
      xa = {xa[6:0], xa[7] ^ xa[5] ^ xa[4] ^ xa[3]};
      xb = {xb[6:0], xb[7] ^ xb[5] ^ xb[4] ^ xb[3]};
    end
  endtask

  task automatic launch(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    corr  = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_accept_state"}, dbg_state, RUN);
    check({tag, "_no_valid_at_k"}, valid, 1'b0);
  endtask

  // Called 1ns after the accepting edge; walks edges k+1 .. k+L+1.
  task automatic collect(input bit mid_poke);
    bit         seen[256];
    logic [1:0] e;
    n_valid = 0; n_sa = 0; n_sb = 0; n_and = 0; n_eq = 0;
    last_pos = 0; done_at = 0; busy_bad = 0; seq_err = 0;
    lfsr_distinct = 0; lfsr_dup = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[dut.w_lfsr_a] = 1'b1;
    lfsr_distinct = (dut.w_lfsr_a != 8'd0) ? 1 : 0;
    for (int c = 1; c <= L + 1; c++) begin
      if (mid_poke && c == 100) begin
        start = 1'b1;
        a_in  = 8'd7;
        b_in  = 8'd200;
        corr  = ~corr;
      end
      if (mid_poke && c == 101) start = 1'b0;
      @(posedge clk); #1;
      if (valid) begin
        if (n_valid < L) begin
          cap_sa[n_valid] = sa;
          cap_sb[n_valid] = sb;
        end
        n_valid++;
        n_sa  += int'(sa);
        n_sb  += int'(sb);
        n_and += int'(sa & sb);
        n_eq  += int'(sa == sb);
        if (last) last_pos = n_valid;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if ({sa, sb} !== e) seq_err++;
        end else begin
          seq_err++;
        end
      end
      if (done && done_at == 0) done_at = c;
      if (!busy) busy_bad++;
      if (c < L) begin
        if (dut.w_lfsr_a == 8'd0 || seen[dut.w_lfsr_a]) lfsr_dup++;
        else lfsr_distinct++;
        seen[dut.w_lfsr_a] = 1'b1;
      end
    end
  endtask

  task automatic check_stream(input string tag, input int ones_a, input int ones_b);
    check({tag, "_valid_count"}, n_valid, L);
    check({tag, "_last_pos"}, last_pos, L);
    check({tag, "_done_cycle"}, done_at, L + 1);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_sa_ones"}, n_sa, ones_a);
    check({tag, "_sb_ones"}, n_sb, ones_b);
  endtask

  initial begin
    int done_seen;
    int same;

    rst = 1'b0; start = 1'b0; a_in = 8'd0; b_in = 8'd0; corr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {sa, sb, valid, last, busy, done}, 6'b0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", {sa, sb, valid, last, busy, done}, 6'b0);

    // Extremes: all-zero and all-one densities.
    model(8'd0, 8'd255, 1'b0);
    launch("t1", 8'd0, 8'd255, 1'b0);
    collect(1'b0);
    check_stream("t1", 0, 255);
    @(posedge clk); #1;
    check("t1_done_drops", {done, busy, valid}, 3'b0);

    // Independent LFSRs. The two seeds sit one LFSR step apart, so the
    // streams are strongly related; the AND count comes from the model.
    model(8'd128, 8'd64, 1'b0);
    launch("t2", 8'd128, 8'd64, 1'b0);
    collect(1'b0);
    check_stream("t2", 128, 64);
    check("t2_and_ones", n_and, exp_and);
    check("t2_lfsr_distinct", lfsr_distinct, L);
    check("t2_lfsr_dup", lfsr_dup, 0);
    @(posedge clk); #1;

    // Shared LFSR: equal magnitudes give identical streams.
    model(8'd100, 8'd100, 1'b1);
    launch("t3", 8'd100, 8'd100, 1'b1);
    collect(1'b0);
    check_stream("t3", 100, 100);
    check("t3_equal_bits", n_eq, L);
    @(posedge clk); #1;

    // Shared LFSR: AND gives the minimum.
    model(8'd100, 8'd50, 1'b1);
    launch("t4", 8'd100, 8'd50, 1'b1);
    collect(1'b0);
    check_stream("t4", 100, 50);
    check("t4_and_min", n_and, 50);
    @(posedge clk); #1;

    // Start and inputs disturbed mid-RUN: latched values must hold.
    model(8'd30, 8'd220, 1'b0);
    launch("t5", 8'd30, 8'd220, 1'b0);
    collect(1'b1);
    check_stream("t5", 30, 220);
    @(posedge clk); #1;
    check("t5_no_restart", {dbg_state == IDLE, busy, valid}, 3'b100);

    // Asynchronous abort at valid cycle 40.
    launch("t6", 8'd255, 8'd255, 1'b0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    check("t6_pre_abort", {valid, sa, sb, busy}, 4'b1111);
    #2 rst = 1'b0;
    #1;
    check("t6_async_drop", {sa, sb, valid, last, busy, done}, 6'b0);
    check("t6_async_state", dbg_state, IDLE);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      done_seen += int'(done);
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      done_seen += int'(done);
    end
    check("t6_no_done", done_seen, 0);
    model(8'd200, 8'd17, 1'b0);
    launch("t6r", 8'd200, 8'd17, 1'b0);
    collect(1'b0);
    check_stream("t6r", 200, 17);
    @(posedge clk); #1;

    // Back-to-back with start held: streams at k, k+L+2, k+2L+4.
    a_in = 8'd77; b_in = 8'd150; corr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("t7_accept0", dbg_state, RUN);
    model(8'd77, 8'd150, 1'b0);
    collect(1'b0);
    check_stream("t7a", 77, 150);
    for (int i = 0; i < L; i++) begin
      ref_sa[i] = cap_sa[i];
      ref_sb[i] = cap_sb[i];
    end
    for (int s = 1; s <= 2; s++) begin
      @(posedge clk); #1;
      check($sformatf("t7_accept%0d", s), dbg_state, RUN);
      check($sformatf("t7_gap_idle%0d", s), {valid, busy, done}, 3'b0);
      model(8'd77, 8'd150, 1'b0);
      collect(1'b0);
      check_stream($sformatf("t7s%0d", s), 77, 150);
      same = 0;
      for (int i = 0; i < L; i++) same += int'(cap_sa[i] == ref_sa[i] && cap_sb[i] == ref_sb[i]);
      check($sformatf("t7_repeat%0d", s), same, L);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t7_idle_after", {dbg_state == IDLE, busy}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
